// File: rtl/stat_pkg.sv
// stat_pkg: shared widths, FSM states and counter sizing for the std-dev engine
package stat_pkg;
    localparam int DATA_W = 31;
    localparam int N_W = 8;
    function automatic int num_w(input int data_w);
        return 2 * data_w;
    endfunction
    function automatic int cnt_w(input int steps);
        return $clog2(steps);
    endfunction
    typedef enum logic [2:0] {IDLE, MUL, DIV, SQRT, DONE} state_t;
endpackage

// File: rtl/stat_std_engine_if.sv
// stat_std_engine_if: request/result bundle between the accumulator, the engine and the display mux
interface stat_std_engine_if #(parameter int DATA_W = 31, parameter int N_W = 8);
    logic start;
    logic [N_W-1:0] n_in;
    logic [DATA_W-1:0] sum_in, sumsq_in;
    logic busy, done, err;
    logic [2*DATA_W-1:0] var_out;
    logic [DATA_W-1:0] std_out;
    modport master(output start, n_in, sum_in, sumsq_in, input busy, done, err, var_out, std_out);
    modport slave(input start, n_in, sum_in, sumsq_in, output busy, done, err, var_out, std_out);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, MSB first
module seq_divider import stat_pkg::*; #(
    parameter int Q_W = 62,
    parameter int D_W = 16
) (
    input logic clk,
    input logic rst,
    input logic start,
    input logic [Q_W-1:0] dividend,
    input logic [D_W-1:0] divisor,
    output logic [Q_W-1:0] quotient,
    output logic done
);
    localparam int CW = cnt_w(Q_W);
    logic [Q_W-1:0] q;
    logic [D_W-1:0] d, rem;
    logic [CW-1:0] cnt;
    logic active, ge;
    logic [D_W:0] r2;
    // dividend bits leave q at the top while quotient bits enter at the bottom
    assign r2 = {rem, q[Q_W-1]};
    assign ge = r2 >= {1'b0, d};
    assign quotient = q;
    assign done = active && cnt == CW'(Q_W - 1);
    always_ff @(posedge clk)
        if (rst) begin
            q <= '0;
            d <= '0;
            rem <= '0;
            cnt <= '0;
            active <= 1'b0;
        end else if (start) begin
            q <= dividend;
            d <= divisor;
            rem <= '0;
            cnt <= '0;
            active <= 1'b1;
        end else if (active) begin
            rem <= ge ? D_W'(r2 - {1'b0, d}) : r2[D_W-1:0];
            q <= {q[Q_W-2:0], ge};
            cnt <= cnt + 1'b1;
            active <= !done;
        end
endmodule

// File: rtl/stat_std_engine.sv
// stat_std_engine: floor variance by restoring division, then floor sqrt, one bit per cycle
module stat_std_engine import stat_pkg::*; #(
    parameter int DATA_W = stat_pkg::DATA_W,
    parameter int N_W = stat_pkg::N_W
) (
    input logic clk,
    input logic rst,
    stat_std_engine_if.slave bus
);
    localparam int NUM_W = num_w(DATA_W);
    localparam int SQ_N = NUM_W / 2;
    localparam int CW = cnt_w(SQ_N);
    localparam int SW = CW + 1;
    localparam int R_W = DATA_W + 5;
    state_t state;
    logic [N_W-1:0] n_q;
    logic [DATA_W-1:0] sum_q, sumsq_q, root, root_nx, std_q;
    logic [NUM_W:0] num;
    logic [2*N_W-1:0] den;
    logic [NUM_W-1:0] quo, var_q;
    logic [CW-1:0] cnt;
    logic [R_W-1:0] rem, r_sh, r_nx;
    logic [1:0] pair;
    logic bad, div_done, done_q, err_q;
    assign num = (NUM_W+1)'(n_q) * (NUM_W+1)'(sumsq_q) - (NUM_W+1)'(sum_q) * (NUM_W+1)'(sum_q);
    assign den = (2*N_W)'(n_q) * (2*N_W)'(n_q);
    assign bad = n_q == '0 || num[NUM_W];
    // non-restoring sqrt: the remainder sign picks add or subtract, no restore step needed
    assign pair = 2'(quo >> (SW'(NUM_W - 2) - {cnt, 1'b0}));
    assign r_sh = R_W'({rem, pair});
    assign r_nx = rem[R_W-1] ? r_sh + R_W'({root, 2'b11}) : r_sh - R_W'({root, 2'b01});
    assign root_nx = DATA_W'({root, ~r_nx[R_W-1]});
    assign bus.busy = state != IDLE;
    assign bus.done = done_q;
    assign bus.err = err_q;
    assign bus.var_out = var_q;
    assign bus.std_out = std_q;
    seq_divider #(.Q_W(NUM_W), .D_W(2*N_W)) u_div (
        .clk(clk),
        .rst(rst),
        .start(state == MUL && !bad),
        .dividend(num[NUM_W-1:0]),
        .divisor(den),
        .quotient(quo),
        .done(div_done)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            n_q <= '0;
            sum_q <= '0;
            sumsq_q <= '0;
            rem <= '0;
            root <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            var_q <= '0;
            std_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    n_q <= bus.n_in;
                    sum_q <= bus.sum_in;
                    sumsq_q <= bus.sumsq_in;
                    state <= MUL;
                end
                MUL: if (bad) begin
                    var_q <= '0;
                    std_q <= '0;
                    err_q <= 1'b1;
                    done_q <= 1'b1;
                    state <= DONE;
                end else state <= DIV;
                DIV: if (div_done) begin
                    cnt <= '0;
                    rem <= '0;
                    root <= '0;
                    state <= SQRT;
                end
                SQRT: begin
                    cnt <= cnt + 1'b1;
                    rem <= r_nx;
                    root <= root_nx;
                    if (cnt == CW'(SQ_N - 1)) begin
                        var_q <= quo;
                        std_q <= root_nx;
                        err_q <= 1'b0;
                        done_q <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule
